alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 p0_req_valid  in  1  port-0 request valid.
REQ-006 p0_req_ready  out  1  port-0 request accepted this cycle.
REQ-007 p0_a, p0_b  in  32 each  port-0 operands.
REQ-008 p0_op  in  4  port-0 ALUop: ADD=0000 SUB=0001 AND=0010 OR=0011 XOR=0100 SLT=0101 SLTU=0110 SLL=0111 SRA=1000 SRL=1001 COPY_B=1010.
REQ-009 p0_rsp_valid  out  1  port-0 result held.
REQ-010 p0_rsp_ready  in  1  port-0 consumer takes result.
REQ-011 p0_rsp_data  out  32  port-0 result.
REQ-012 p1_req_valid, p1_req_ready, p1_a, p1_b, p1_op, p1_rsp_valid, p1_rsp_ready, p1_rsp_data: identical to the p0_* ports, for port 1.
REQ-013 alu_a, alu_b  out  32 each  operands driven to the shared ALU.
REQ-014 alu_op  out  4  ALUop driven to the shared ALU.
REQ-015 alu_out  in  32  combinational ALU result, same cycle.

Function
REQ-016 A transfer occurs on any channel when valid and ready are both high at a rising clk edge.
REQ-017 Port i is eligible when pi_req_valid=1 and (pi_rsp_valid=0 or pi_rsp_ready=1).
REQ-018 At most one port is granted per cycle: if both are eligible, the port selected by rr_ptr wins; if one is eligible, it wins; if none is eligible, there is no grant.
REQ-019 pi_req_ready is high only when port i is granted; this is combinational from the current inputs and state.
REQ-020 On a grant to port i: alu_a=pi_a, alu_b=pi_b, alu_op=pi_op. With no grant: alu_a=0, alu_b=0, alu_op=0000.
REQ-021 At the granting edge: pi_rsp_data <= alu_out and pi_rsp_valid <= 1 (latency: result visible the cycle after acceptance).
REQ-022 Response consumed (rsp fire) with no new grant to the same port: pi_rsp_valid <= 0 and pi_rsp_data is held.
REQ-023 Response consumed and a new grant to the same port in the same cycle: pi_rsp_valid stays 1 and pi_rsp_data takes the new result (back-to-back, 1 op/cycle per port).
REQ-024 While pi_rsp_valid=1 and pi_rsp_ready=0: pi_rsp_data is stable and port i is not granted.
REQ-025 rr_ptr (1 bit) is set to the other port after every grant and is unchanged when there is no grant.
REQ-026 Fairness: a continuously eligible port is granted within 2 cycles.
REQ-027 Aggregate throughput is 1 grant/cycle; a port that is eligible alone is granted every cycle.
REQ-028 op codes 1011-1111 are forwarded unchanged; the response is still delivered with data equal to alu_out (contents undefined).
REQ-029 Requesters hold a, b and op stable while valid=1 and ready=0; the arbiter does not register request operands.

Reset
REQ-030 reset_n=0 asynchronously forces p0/p1_rsp_valid=0, p0/p1_rsp_data=0 and rr_ptr=0 (port 0 has priority first).
REQ-031 While reset_n=0: p0/p1_req_ready=0, alu_a=0, alu_b=0, alu_op=0000.
REQ-032 Reset asserted mid-operation discards held responses; requests that were in flight and not yet accepted are not granted until reset_n=1.
REQ-033 Grants resume on the first rising edge after reset_n deasserts; reset_n deassertion is synchronized to clk externally.

Verification
REQ-034 Single port: p0 ADD a=5 b=7, rsp_ready=1 -> p0_req_ready=1 the same cycle; next cycle p0_rsp_valid=1, p0_rsp_data=12; p1 untouched.
REQ-035 Contention after reset: both ports valid; p0 SUB 10-3; p1 SRA 0x80000000>>>4 -> cycle 0 grants p0 (rsp 7); cycle 1 grants p1 (rsp 0xF8000000); with both held valid, grants alternate p0,p1,p0,...
REQ-036 Backpressure: p1 SLT a=0xFFFFFFFF b=1 with p1_rsp_ready=0 for 3 cycles -> p1_rsp_data=1 stable; a second p1 request is not accepted; p0 requests are granted every cycle meanwhile.
REQ-037 Streaming: p0 COPY_B b=1,2,3,4 on consecutive cycles with rsp_ready=1 -> 4 accepts in 4 cycles; rsp_data sequence 1,2,3,4 with rsp_valid continuously high.
REQ-038 Reset mid-stream: reset_n low while p0_rsp_valid=1 -> rsp_valid=0 and rsp_data=0 immediately (asynchronously); after release, first contention is won by p0.
REQ-039 Idle: no valid on either port -> alu_a=alu_b=0, alu_op=0000, rr_ptr unchanged over 10 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requester ports share one combinational ALU.
//
// Each cycle at most one port is granted. The granted port's operands go to
// the shared ALU, and the ALU result is registered into that port's response
// slot. If both ports are eligible, a 1-bit round-robin pointer decides which
// one wins. A port whose response is still waiting to be taken is not
// eligible. A new grant can reuse the slot in the same cycle the old response
// is consumed, so each port can complete one operation per cycle.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   pN_req_valid/ready      request handshake (ready = granted this cycle)
//   pN_a, pN_b, pN_op       request operands and ALU op (held by the requester)
//   pN_rsp_valid/ready      response handshake
//   pN_rsp_data             registered result
//   alu_a, alu_b, alu_op    operands and op driven to the shared ALU
//   alu_out                 ALU result, available in the same cycle
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [DATA_W-1:0] p0_a,
    input  logic [DATA_W-1:0] p0_b,
    input  logic [3:0]        p0_op,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_data,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [DATA_W-1:0] p1_a,
    input  logic [DATA_W-1:0] p1_b,
    input  logic [3:0]        p1_op,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_data,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out
);

    logic              r_p0_rsp_valid;
    logic              r_p1_rsp_valid;
    logic [DATA_W-1:0] r_p0_rsp_data;
    logic [DATA_W-1:0] r_p1_rsp_data;
    logic              r_rr_ptr;      // 0: port 0 wins a tie, 1: port 1 wins

    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt0;
    logic              w_gnt1;

    // Gating with reset_n keeps grants and ALU drive quiet while reset is
    // held. Otherwise a request that is already pending would appear to be
    // accepted during reset.
    assign w_elig0 = reset_n & p0_req_valid & (~r_p0_rsp_valid | p0_rsp_ready);
    assign w_elig1 = reset_n & p1_req_valid & (~r_p1_rsp_valid | p1_rsp_ready);

    assign w_gnt0 = w_elig0 & (~w_elig1 | ~r_rr_ptr);
    assign w_gnt1 = w_elig1 & (~w_elig0 |  r_rr_ptr);

    assign p0_req_ready = w_gnt0;
    assign p1_req_ready = w_gnt1;
    assign p0_rsp_valid = r_p0_rsp_valid;
    assign p1_rsp_valid = r_p1_rsp_valid;
    assign p0_rsp_data  = r_p0_rsp_data;
    assign p1_rsp_data  = r_p1_rsp_data;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 4'b0000;
        if (w_gnt0) begin
            alu_a  = p0_a;
            alu_b  = p0_b;
            alu_op = p0_op;
        end else if (w_gnt1) begin
            alu_a  = p1_a;
            alu_b  = p1_b;
            alu_op = p1_op;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p0_rsp_valid <= 1'b0;
            r_p0_rsp_data  <= '0;
        end else if (w_gnt0) begin
            r_p0_rsp_valid <= 1'b1;
            r_p0_rsp_data  <= alu_out;
        end else if (p0_rsp_ready) begin
            r_p0_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_rsp_valid <= 1'b0;
            r_p1_rsp_data  <= '0;
        end else if (w_gnt1) begin
            r_p1_rsp_valid <= 1'b1;
            r_p1_rsp_data  <= alu_out;
        end else if (p1_rsp_ready) begin
            r_p1_rsp_valid <= 1'b0;
        end
    end

    // After a grant, the pointer moves to the other port. It holds when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr_ptr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
    logic [31:0] p0_a, p0_b, p0_rsp_data;
    logic [3:0]  p0_op;
    logic        p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
    logic [31:0] p1_a, p1_b, p1_rsp_data;
    logic [3:0]  p1_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_a(p0_a), .p0_b(p0_b), .p0_op(p0_op),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_a(p1_a), .p1_b(p1_b), .p1_op(p1_op),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(p1_rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
    );

    // Reference ALU standing in for the shared unit outside the arbiter
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0110: alu_out = {31'd0, alu_a < alu_b};
            4'b0111: alu_out = alu_a << alu_b[4:0];
            4'b1000: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1001: alu_out = alu_a >> alu_b[4:0];
            4'b1010: alu_out = alu_b;
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_req_valid = 0; p1_req_valid = 0;
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        p0_a = 0; p0_b = 0; p0_op = 0;
        p1_a = 0; p1_b = 0; p1_op = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        p0_req_valid = 1; p0_a = 32'd9; p0_b = 32'd9;
        #2;
        chk("reset_p0_req_ready", {31'd0, p0_req_ready}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_op", {28'd0, alu_op}, 32'd0);
        tick(); tick();
        chk("reset_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("reset_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
        chk("reset_p0_rsp_data", p0_rsp_data, 32'd0);
        chk("reset_p1_rsp_data", p1_rsp_data, 32'd0);
        reset_n = 1;
        p0_req_valid = 0;
    endtask

    task automatic test_contention();
        p0_req_valid = 1; p0_op = 4'b0001; p0_a = 32'd10; p0_b = 32'd3;
        p1_req_valid = 1; p1_op = 4'b1000; p1_a = 32'h8000_0000; p1_b = 32'd4;
        #1;
        chk("cont_c0_p0_ready", {31'd0, p0_req_ready}, 32'd1);
        chk("cont_c0_p1_ready", {31'd0, p1_req_ready}, 32'd0);
        chk("cont_c0_alu_a", alu_a, 32'd10);
        tick();
        chk("cont_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd1);
        chk("cont_p0_rsp_data", p0_rsp_data, 32'd7);
        chk("cont_c1_p1_ready", {31'd0, p1_req_ready}, 32'd1);
        chk("cont_c1_p0_ready", {31'd0, p0_req_ready}, 32'd0);
        tick();
        chk("cont_p1_rsp_data", p1_rsp_data, 32'hF800_0000);
        chk("cont_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd1);
        chk("cont_p0_rsp_drop", {31'd0, p0_rsp_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("cont_alt_p0", {31'd0, p0_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_alt_p1", {31'd0, p1_req_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_single();
        p0_req_valid = 1; p0_op = 4'b0000; p0_a = 32'd5; p0_b = 32'd7;
        #1;
        chk("single_p0_ready", {31'd0, p0_req_ready}, 32'd1);
        chk("single_p1_ready", {31'd0, p1_req_ready}, 32'd0);
        tick();
        p0_req_valid = 0;
        chk("single_rsp_valid", {31'd0, p0_rsp_valid}, 32'd1);
        chk("single_rsp_data", p0_rsp_data, 32'd12);
        chk("single_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
        tick();
    endtask

    task automatic test_undef_op();
        p0_req_valid = 1; p0_op = 4'b1011; p0_a = 32'd1; p0_b = 32'd2;
        #1;
        chk("undef_alu_op", {28'd0, alu_op}, 32'd11);
        tick();
        p0_req_valid = 0;
        chk("undef_rsp_valid", {31'd0, p0_rsp_valid}, 32'd1);
        chk("undef_rsp_data", p0_rsp_data, 32'hDEAD_BEEF);
        tick();
    endtask

    task automatic test_backpressure();
        p1_req_valid = 1; p1_op = 4'b0101; p1_a = 32'hFFFF_FFFF; p1_b = 32'd1;
        p1_rsp_ready = 0;
        #1;
        chk("bp_first_p1_ready", {31'd0, p1_req_ready}, 32'd1);
        tick();
        chk("bp_p1_rsp_data", p1_rsp_data, 32'd1);
        p1_op = 4'b0000; p1_a = 32'd1; p1_b = 32'd1;
        p0_req_valid = 1; p0_op = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            p0_a = i; p0_b = i;
            #1;
            chk("bp_p1_blocked", {31'd0, p1_req_ready}, 32'd0);
            chk("bp_p0_granted", {31'd0, p0_req_ready}, 32'd1);
            tick();
            chk("bp_p1_data_stable", p1_rsp_data, 32'd1);
            chk("bp_p1_valid_held", {31'd0, p1_rsp_valid}, 32'd1);
            chk("bp_p0_rsp_data", p0_rsp_data, 2 * i);
        end
        p1_rsp_ready = 1;
        #1;
        chk("bp_release_p1_ready", {31'd0, p1_req_ready}, 32'd1);
        tick();
        chk("bp_b2b_p1_valid", {31'd0, p1_rsp_valid}, 32'd1);
        chk("bp_b2b_p1_data", p1_rsp_data, 32'd2);
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        p0_req_valid = 1; p0_op = 4'b1010; p0_a = 32'h5555_5555;
        for (int k = 1; k <= 4; k++) begin
            p0_b = k;
            #1;
            if (p0_req_ready === 1'b1) accepts++;
            tick();
            chk("stream_rsp_valid", {31'd0, p0_rsp_valid}, 32'd1);
            chk("stream_rsp_data", p0_rsp_data, k);
        end
        chk("stream_accepts", accepts, 32'd4);
        p0_req_valid = 0;
        tick();
        chk("stream_drain_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("stream_hold_data", p0_rsp_data, 32'd4);
    endtask

    task automatic test_reset_mid();
        p0_req_valid = 1; p0_op = 4'b0000; p0_a = 32'd1; p0_b = 32'd2;
        tick();
        chk("midrst_pre_valid", {31'd0, p0_rsp_valid}, 32'd1);
        chk("midrst_pre_data", p0_rsp_data, 32'd3);
        #2;
        reset_n = 0;
        #1;
        chk("midrst_async_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("midrst_async_data", p0_rsp_data, 32'd0);
        chk("midrst_no_grant", {31'd0, p0_req_ready}, 32'd0);
        p1_req_valid = 1; p1_op = 4'b0000; p1_a = 32'd4; p1_b = 32'd4;
        tick(); tick();
        chk("midrst_held_alu_a", alu_a, 32'd0);
        reset_n = 1;
        #1;
        chk("midrst_p0_wins", {31'd0, p0_req_ready}, 32'd1);
        chk("midrst_p1_waits", {31'd0, p1_req_ready}, 32'd0);
        p1_req_valid = 0;
        tick();
    endtask

    task automatic test_idle();
        idle_inputs();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("idle_alu_a", alu_a, 32'd0);
            chk("idle_alu_b", alu_b, 32'd0);
            chk("idle_alu_op", {28'd0, alu_op}, 32'd0);
            tick();
        end
        p0_req_valid = 1; p1_req_valid = 1;
        #1;
        chk("idle_ptr_p1_wins", {31'd0, p1_req_ready}, 32'd1);
        chk("idle_ptr_p0_loses", {31'd0, p0_req_ready}, 32'd0);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_undef_op();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
